// File: rtl/animation_sequencer.sv
// animation_sequencer
// Frame/animation scheduler for the 7-segment animation engine.
// A prescaler turns clk into frame ticks. Each tick steps the frame index
// from 0 up to the per-animation `limit`. After REPEATS loops, the sequencer
// either auto-advances to the next animation or repeats the current one.
// `next` and `load` give manual selection.
//
// Optional feature macro: SEQ_PAUSE_EN
//   When defined, this adds a `pause` input. While `pause` is high in RUN, the
//   prescaler, frame and loop counter freeze. `next`, `load` and `ena` still act.
module animation_sequencer #(
    parameter int TICK_DIV = 12_000_000,
    parameter int NUM_ANI  = 34,
    parameter int REPEATS  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       auto,
    input  logic       next,
    input  logic       load,
    input  logic [5:0] sel,
    input  logic [5:0] limit,
`ifdef SEQ_PAUSE_EN
    input  logic       pause,
`endif
    output logic [5:0] animation,
    output logic [5:0] frame,
    output logic       frame_stb,
    output logic       ani_done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LW = (REPEATS > 1) ? $clog2(REPEATS) : 1;
    localparam logic [PW-1:0] PS_LAST   = PW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LOOP_LAST = LW'(REPEATS - 1);
    localparam logic [5:0]    ANI_LAST  = 6'(NUM_ANI - 1);
    localparam logic [6:0]    ANI_COUNT = 7'(NUM_ANI);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SWITCH
    } state_t;

    state_t        r_state, w_state_next;
    logic [5:0]    r_animation, w_animation_next;
    logic [5:0]    r_frame, w_frame_next;
    logic [PW-1:0] r_prescale, w_prescale_next;
    logic [LW-1:0] r_loop, w_loop_next;
    logic [5:0]    r_target, w_target_next;
    logic          r_frame_stb, w_frame_stb_next;
    logic          r_ani_done, w_ani_done_next;

    logic          w_pause;
    logic          w_tick;
    logic [5:0]    w_ani_inc;
    logic [5:0]    w_sel_target;

`ifdef SEQ_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_tick = (r_prescale == PS_LAST);

    // Wrap the successor of the last valid animation back to 0.
    assign w_ani_inc = (r_animation == ANI_LAST) ? 6'd0 : r_animation + 6'd1;

    // An out-of-range selection falls back to animation 0.
    assign w_sel_target = ({1'b0, sel} >= ANI_COUNT) ? 6'd0 : sel;

    // State and data registers. Reset is asynchronous, so outputs clear immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_animation <= 6'd0;
            r_frame     <= 6'd0;
            r_prescale  <= '0;
            r_loop      <= '0;
            r_target    <= 6'd0;
            r_frame_stb <= 1'b0;
            r_ani_done  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_animation <= w_animation_next;
            r_frame     <= w_frame_next;
            r_prescale  <= w_prescale_next;
            r_loop      <= w_loop_next;
            r_target    <= w_target_next;
            r_frame_stb <= w_frame_stb_next;
            r_ani_done  <= w_ani_done_next;
        end
    end

    // Next-state logic. Priority: ena low > load > next > tick.
    // Dropping into IDLE does not strobe. Consumers resync on the next strobe
    // after the sequencer runs again.
    always_comb begin
        w_state_next     = r_state;
        w_animation_next = r_animation;
        w_frame_next     = r_frame;
        w_prescale_next  = r_prescale;
        w_loop_next      = r_loop;
        w_target_next    = r_target;
        w_frame_stb_next = 1'b0;
        w_ani_done_next  = 1'b0;

        if (!ena) begin
            w_state_next    = S_IDLE;
            w_frame_next    = 6'd0;
            w_prescale_next = '0;
            w_loop_next     = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_RUN;
                end
                S_RUN: begin
                    if (load) begin
                        w_target_next = w_sel_target;
                        w_state_next  = S_SWITCH;
                    end else if (next) begin
                        w_target_next = w_ani_inc;
                        w_state_next  = S_SWITCH;
                    end else if (!w_pause) begin
                        if (w_tick) begin
                            w_prescale_next  = '0;
                            w_frame_stb_next = 1'b1;
                            if (r_frame < limit) begin
                                w_frame_next = r_frame + 6'd1;
                            end else begin
                                // Wrapping to frame 0 completes one loop.
                                w_frame_next = 6'd0;
                                if (r_loop == LOOP_LAST) begin
                                    w_loop_next     = '0;
                                    w_ani_done_next = 1'b1;
                                    if (auto) begin
                                        w_target_next = w_ani_inc;
                                        w_state_next  = S_SWITCH;
                                    end
                                end else begin
                                    w_loop_next = r_loop + LW'(1);
                                end
                            end
                        end else begin
                            w_prescale_next = r_prescale + PW'(1);
                        end
                    end
                end
                S_SWITCH: begin
                    // Commit the new animation. The restarted prescaler gives the
                    // downstream `limit` lookup a full frame to settle.
                    w_animation_next = r_target;
                    w_frame_next     = 6'd0;
                    w_prescale_next  = '0;
                    w_loop_next      = '0;
                    w_frame_stb_next = 1'b1;
                    w_state_next     = S_RUN;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    assign animation = r_animation;
    assign frame     = r_frame;
    assign frame_stb = r_frame_stb;
    assign ani_done  = r_ani_done;

endmodule

// File: tb/tb_animation_sequencer.sv
// Self-checking bench for animation_sequencer (TICK_DIV=4, NUM_ANI=34, REPEATS=3).
// Expected strobe events (cycle, animation, frame, ani_done) are queued as
// stimulus is applied. A monitor pops and compares one entry per frame_stb.
module tb_animation_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       auto;
    logic       next;
    logic       load;
    logic [5:0] sel;
    logic [5:0] limit;
`ifdef SEQ_PAUSE_EN
    logic       pause;
`endif
    logic [5:0] animation;
    logic [5:0] frame;
    logic       frame_stb;
    logic       ani_done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [5:0] ani;
        logic [5:0] frm;
        logic       done;
    } exp_t;

    exp_t q[$];

    animation_sequencer #(
        .TICK_DIV(4),
        .NUM_ANI (34),
        .REPEATS (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .auto     (auto),
        .next     (next),
        .load     (load),
        .sel      (sel),
        .limit    (limit),
`ifdef SEQ_PAUSE_EN
        .pause    (pause),
`endif
        .animation(animation),
        .frame    (frame),
        .frame_stb(frame_stb),
        .ani_done (ani_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every strobe must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (frame_stb === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_stb cyc=%0d ani=%0d frame=%0d done=%b required=no_strobe",
                         cyc, animation, frame, ani_done);
            end else begin
                e = q.pop_front();
                if (cyc !== e.cyc || animation !== e.ani || frame !== e.frm || ani_done !== e.done) begin
                    errors++;
                    $display("FAIL stb_event got cyc=%0d ani=%0d frame=%0d done=%b required cyc=%0d ani=%0d frame=%0d done=%b",
                             cyc, animation, frame, ani_done, e.cyc, e.ani, e.frm, e.done);
                end else begin
                    $display("event cyc=%0d ani=%0d frame=%0d done=%b ok", cyc, animation, frame, ani_done);
                end
            end
        end else if (ani_done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_without_stb cyc=%0d ani_done=1 required=0", cyc);
        end
    end

    task automatic push(input int c, input logic [5:0] a, input logic [5:0] f, input logic d);
        exp_t e;
        e.cyc = c; e.ani = a; e.frm = f; e.done = d;
        q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // One-cycle command pulse, starting at the current negedge.
    task automatic pulse_cmd(input logic l, input logic n, input logic [5:0] s);
        load = l; next = n; sel = s;
        @(negedge clk);
        load = 1'b0; next = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ena = 1'b0; auto = 1'b0; load = 1'b0; next = 1'b0;
`ifdef SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (animation !== 6'd0) begin errors++; $display("FAIL reset_animation got=%0d required=0", animation); end
        checks++;
        if (frame !== 6'd0) begin errors++; $display("FAIL reset_frame got=%0d required=0", frame); end
        checks++;
        if (frame_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got=%b required=0", frame_stb); end
        checks++;
        if (ani_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b required=0", ani_done); end
        $display("reset checked ani=%0d frame=%0d", animation, frame);
    endtask

    // auto=1, limit=2: three loops of 0,1,2 then advance to animation 1.
    task automatic test_auto_rotate();
        int c0;
        limit = 6'd2; auto = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 9; k++) push(c0 + 1 + 4 * k, 6'd0, 6'(k % 3), (k == 9));
        push(c0 + 38, 6'd1, 6'd0, 1'b0);
        push(c0 + 42, 6'd1, 6'd1, 1'b0);
        ena = 1'b1;
        wait_until(c0 + 43);
        ena = 1'b0;
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL auto_drain pending=%0d required=0", q.size()); end
        do_reset();
    endtask

    // auto=0, limit=1: animation stays 0, ani_done on every 6th tick.
    task automatic test_manual_hold();
        int c0;
        limit = 6'd1; auto = 1'b0;
        c0 = cyc;
        for (int k = 1; k <= 12; k++) push(c0 + 1 + 4 * k, 6'd0, 6'(k % 2), (k % 6 == 0));
        ena = 1'b1;
        wait_until(c0 + 51);
        ena = 1'b0;
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL hold_drain pending=%0d required=0", q.size()); end
        do_reset();
    endtask

    // load/next sequence, including the wrap, an out-of-range sel, and load+next together.
    task automatic test_load_next();
        int c0;
        logic       l_tab [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       n_tab [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [5:0] s_tab [6] = '{6'd33, 6'd0, 6'd5, 6'd40, 6'd5, 6'd0};
        logic [5:0] e_tab [6] = '{6'd33, 6'd0, 6'd5, 6'd0, 6'd5, 6'd6};
        limit = 6'd5; auto = 1'b0;
        c0 = cyc;
        ena = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            push(cyc + 2, e_tab[i], 6'd0, 1'b0);
            pulse_cmd(l_tab[i], n_tab[i], s_tab[i]);
            @(negedge clk);
        end
        ena = 1'b0;
        @(negedge clk);
        checks++;
        if (animation !== 6'd6) begin errors++; $display("FAIL load_next_final got=%0d required=6", animation); end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL load_drain pending=%0d required=0 (start %0d)", q.size(), c0); end
        do_reset();
    endtask

    // limit=0: frame stays 0 and every tick is a loop, done every 3rd tick.
    task automatic test_one_frame();
        int c0;
        limit = 6'd0; auto = 1'b0;
        c0 = cyc;
        for (int k = 1; k <= 6; k++) push(c0 + 1 + 4 * k, 6'd0, 6'd0, (k % 3 == 0));
        ena = 1'b1;
        wait_until(c0 + 27);
        ena = 1'b0;
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL oneframe_drain pending=%0d required=0", q.size()); end
        do_reset();
    endtask

    // ena dropped mid-frame clears frame and keeps animation. Re-enable restarts the tick timing.
    task automatic test_ena_drop();
        int c0;
        limit = 6'd3; auto = 1'b0;
        c0 = cyc;
        push(c0 + 3, 6'd7, 6'd0, 1'b0);
        push(c0 + 7, 6'd7, 6'd1, 1'b0);
        push(c0 + 11, 6'd7, 6'd2, 1'b0);
        ena = 1'b1;
        @(negedge clk);
        pulse_cmd(1'b1, 1'b0, 6'd7);
        wait_until(c0 + 13);
        ena = 1'b0;
        @(negedge clk);
        checks++;
        if (frame !== 6'd0) begin errors++; $display("FAIL ena_drop_frame got=%0d required=0", frame); end
        checks++;
        if (animation !== 6'd7) begin errors++; $display("FAIL ena_drop_ani got=%0d required=7", animation); end
        push(c0 + 19, 6'd7, 6'd1, 1'b0);
        ena = 1'b1;
        wait_until(c0 + 20);
        ena = 1'b0;
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL ena_drain pending=%0d required=0", q.size()); end
        do_reset();
    endtask

    // Asynchronous reset between edges clears the outputs before the next edge.
    task automatic test_async_reset();
        int c0;
        limit = 6'd3; auto = 1'b0;
        c0 = cyc;
        push(c0 + 3, 6'd9, 6'd0, 1'b0);
        push(c0 + 7, 6'd9, 6'd1, 1'b0);
        ena = 1'b1;
        @(negedge clk);
        pulse_cmd(1'b1, 1'b0, 6'd9);
        wait_until(c0 + 8);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (animation !== 6'd0) begin errors++; $display("FAIL async_rst_ani got=%0d required=0", animation); end
        checks++;
        if (frame !== 6'd0) begin errors++; $display("FAIL async_rst_frame got=%0d required=0", frame); end
        @(negedge clk);
        ena = 1'b0;
        rst = 1'b0;
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL async_drain pending=%0d required=0", q.size()); end
        do_reset();
    endtask

`ifdef SEQ_PAUSE_EN
    // 10 paused cycles delay the first tick by exactly 10 cycles.
    task automatic test_pause();
        int c0;
        limit = 6'd3; auto = 1'b0;
        c0 = cyc;
        push(c0 + 15, 6'd0, 6'd1, 1'b0);
        push(c0 + 19, 6'd0, 6'd2, 1'b0);
        ena = 1'b1;
        wait_until(c0 + 2);
        pause = 1'b1;
        wait_until(c0 + 12);
        pause = 1'b0;
        wait_until(c0 + 20);
        ena = 1'b0;
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL pause_drain pending=%0d required=0", q.size()); end
        do_reset();
    endtask

    // next is honoured while paused. No ticks follow while pause stays high.
    task automatic test_pause_next();
        int c0;
        limit = 6'd3; auto = 1'b0;
        c0 = cyc;
        push(c0 + 3, 6'd1, 6'd0, 1'b0);
        ena = 1'b1; pause = 1'b1;
        @(negedge clk);
        pulse_cmd(1'b0, 1'b1, 6'd0);
        wait_until(c0 + 20);
        checks++;
        if (frame !== 6'd0) begin errors++; $display("FAIL pause_next_frame got=%0d required=0", frame); end
        checks++;
        if (animation !== 6'd1) begin errors++; $display("FAIL pause_next_ani got=%0d required=1", animation); end
        ena = 1'b0; pause = 1'b0;
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL pause_next_drain pending=%0d required=0", q.size()); end
        do_reset();
    endtask
`endif

    initial begin
        rst = 1'b1; ena = 1'b0; auto = 1'b0; next = 1'b0; load = 1'b0;
        sel = 6'd0; limit = 6'd0;
`ifdef SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_auto_rotate();
        test_manual_hold();
        test_load_next();
        test_one_frame();
        test_ena_drop();
        test_async_reset();
`ifdef SEQ_PAUSE_EN
        test_pause();
        test_pause_next();
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
